// File: rtl/pwm_capture_pkg.sv
// -----------------------------------------------------------------------------
// pwm_capture_pkg
// Definitions shared by the PWM capture block and the PWM generator.
//   TPS      : clk ticks per second (100 MHz system clock)
//   state_e  : measurement FSM state encoding
// -----------------------------------------------------------------------------
package pwm_capture_pkg;

  localparam int TPS = 100_000_000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for a first rise; any partial period is discarded
    ST_HIGH = 2'd1,  // line high inside a measured period
    ST_LOW  = 2'd2   // line low, waiting for the rise that closes the period
  } state_e;

endpackage : pwm_capture_pkg

// File: rtl/pwm_capture_sync_edge.sv
// -----------------------------------------------------------------------------
// pwm_capture_sync_edge
// Two-flop synchronizer followed by a one-flop edge detector. rise/fall are
// registered one-cycle pulses appearing 3 clk cycles after the input edge.
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-low reset
//   din    in   asynchronous input line
//   level  out  synchronized line value, aligned with rise/fall
//   rise   out  one-cycle pulse on a 0->1 transition
//   fall   out  one-cycle pulse on a 1->0 transition
// -----------------------------------------------------------------------------
module pwm_capture_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;

  // Every flop resets to 0, so a line that is already high at reset release
  // is seen as a fresh rise three cycles later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make each stage sample the previous
      // stage's value from before this edge; blocking would collapse the chain.
      meta  <= din;
      sync  <= meta;
      level <= sync;
      rise  <= sync & ~level;
      fall  <= ~sync & level;
    end
  end

endmodule : pwm_capture_sync_edge

// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
// Measures high time and period of an asynchronous PWM line in clk cycles and
// flags a line that has stopped toggling.
// Parameters:
//   WIDTH    width of all counters and measurement outputs
//   TIMEOUT  edge-free cycles before the line is declared stuck (>= 2)
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   pwm_in       in   PWM line, asynchronous to clk
//   high_count   out  high cycles of the last complete period
//   period       out  cycles between the last two rises
//   valid        out  one-cycle pulse when high_count/period update
//   stuck        out  no edge for TIMEOUT cycles
//   stuck_level  out  line level at the moment stuck asserted
// -----------------------------------------------------------------------------
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = TPS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] high_count,
  output logic [WIDTH-1:0] period,
  output logic             valid,
  output logic             stuck,
  output logic             stuck_level
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] IDLE_MAX = WIDTH'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] IDLE_PRE = WIDTH'(TIMEOUT - 2);

  logic level;
  logic rise;
  logic fall;

  pwm_capture_sync_edge u_sync_edge (
    .clk   (clk),
    .reset (reset),
    .din   (pwm_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  state_e           state;
  logic [WIDTH-1:0] period_cnt;
  logic [WIDTH-1:0] high_cnt;
  logic [WIDTH-1:0] idle_cnt;
  logic             edge_seen;
  logic             timeout_hit;

  assign edge_seen   = rise | fall;
  // Fires on the edge where idle_cnt steps onto TIMEOUT-1, so stuck becomes
  // visible exactly TIMEOUT cycles after the last detected edge.
  assign timeout_hit = !edge_seen && (idle_cnt == IDLE_PRE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      period_cnt  <= '0;
      high_cnt    <= '0;
      idle_cnt    <= '0;
      high_count  <= '0;
      period      <= '0;
      valid       <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      valid <= 1'b0;

      // Idle timer parks at TIMEOUT-1 so the timeout fires only once.
      if (edge_seen)                idle_cnt <= '0;
      else if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + ONE;

      // Counters restart at 1 on a rise (the rise cycle itself counts) and
      // saturate instead of wrapping.
      if (rise)                        period_cnt <= ONE;
      else if (period_cnt != ALL_ONES) period_cnt <= period_cnt + ONE;

      // The fall cycle is already low time, hence the !fall term.
      if (rise)
        high_cnt <= ONE;
      else if (state == ST_HIGH && !fall && high_cnt != ALL_ONES)
        high_cnt <= high_cnt + ONE;

      if (edge_seen) stuck <= 1'b0;

      if (timeout_hit) begin
        state       <= ST_IDLE;
        stuck       <= 1'b1;
        stuck_level <= level;
      end else begin
        case (state)
          ST_IDLE: if (rise) state <= ST_HIGH;
          ST_HIGH: if (fall) state <= ST_LOW;
          ST_LOW: begin
            if (rise) begin
              state      <= ST_HIGH;
              period     <= period_cnt;
              high_count <= high_cnt;
              valid      <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule : pwm_capture

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter WIDTH, default 32: width of every counter and measurement output.
REQ-002 Parameter TIMEOUT, default 100000000 (one second at 100 MHz): idle cycles with no edge before a line is declared stuck.
REQ-003 clk  input  1  system clock; all logic rising-edge.
REQ-004 reset  input  1  reset; asynchronous, active-low.
REQ-005 pwm_in  input  1  PWM line under measurement; asynchronous to clk.
REQ-006 high_count  output  WIDTH  clk cycles pwm_in was high in the last complete period.
REQ-007 period  output  WIDTH  clk cycles between the last two rising edges.
REQ-008 valid  output  1  one-cycle pulse; high_count/period updated this cycle.
REQ-009 stuck  output  1  level; no edge seen for TIMEOUT cycles.
REQ-010 stuck_level  output  1  synchronized pwm_in value when stuck asserted; don't-care otherwise.

Function
REQ-011 pwm_in SHALL pass a 2-flop synchronizer, then a 1-flop edge detector; rise/fall pulses SHALL appear exactly 3 clk cycles after the input transition.
REQ-012 FSM states: IDLE, HIGH, LOW; IDLE waits for first rise, discarding any partial period.
REQ-013 IDLE->HIGH on rise; HIGH->LOW on fall; LOW->HIGH on rise; any state->IDLE on timeout.
REQ-014 On a rise cycle, period_cnt and high_cnt SHALL load 1; each later cycle period_cnt increments; high_cnt increments only in HIGH.
REQ-015 On rise in LOW: period <= period_cnt, high_count <= high_cnt (pre-reload values), valid = 1 the same cycle.
REQ-016 Rise in IDLE SHALL not assert valid; first valid follows the second rise.
REQ-017 Rise and fall cannot coincide (single synchronized line); a 1-cycle synchronized pulse SHALL give high_count = 1.
REQ-018 Counters SHALL saturate at all-ones, never wrap.
REQ-019 Timeout: idle_cnt resets to 0 on any rise/fall, else increments; when idle_cnt reaches TIMEOUT-1, FSM -> IDLE, stuck <= 1, stuck_level <= synchronized pwm_in.
REQ-020 stuck SHALL clear on the next rise or fall; measurement restarts per REQ-016.
REQ-021 high_count and period SHALL hold last values through timeout (not cleared).
REQ-022 Duty = 100 % is reported only via stuck=1, stuck_level=1; duty = 0 % via stuck=1, stuck_level=0.

Reset
REQ-023 reset low SHALL immediately force: FSM IDLE, all counters 0, high_count 0, period 0, valid 0, stuck 0, stuck_level 0, synchronizer and edge flops 0.
REQ-024 Reset asserted mid-period SHALL discard that period; after release the first valid follows two new rises.
REQ-025 Synchronizer flops SHALL reset to 0, so input high at release produces a rise 3 cycles later (treated as first rise).

Structure
REQ-026 Shared definitions file SHALL hold TPS (100000000) and the FSM state encodings; the PWM generator and this block include the same TPS.
REQ-027 One sub-module, sync_edge (2-flop sync + edge detect, outputs level/rise/fall); FSM, counters, timeout in pwm_capture.

Verification
REQ-028 Period 100 cycles, high 30 -> after 2nd rise, valid every 100 cycles, high_count=30, period=100.
REQ-029 Duty sweep: high 1, 50, 99 of period 100 -> high_count 1, 50, 99; period 100 each.
REQ-030 TIMEOUT=1000, pwm_in held high after valid -> stuck=1, stuck_level=1 exactly 1000 cycles after last edge detect; high_count/period unchanged.
REQ-031 Line held low then restarted at period 20, high 5 -> stuck clears on first rise, first valid after second rise with 5/20.
REQ-032 reset pulsed low mid-HIGH -> all outputs 0 asynchronously; no valid until two rises after release.
REQ-033 1-cycle high glitch every 40 cycles -> high_count=1, period=40.
